// File: rtl/addsub_mx_pkg.sv
// Shared types and helpers for the partitionable pipelined adder/subtractor.
package addsub_mx_pkg;

    // Per-beat operation controls, captured together with the operands.
    typedef struct packed {
        logic addsub;   // 0 = a+b+ci, 1 = a-b-ci
        logic tc;       // 1 = two's-complement operands
        logic sat;      // saturate on overflow
        logic avg;      // halved (L+1)-bit result, overrides sat
        logic split;    // 1 = independent lanes, 0 = one full-width operation
    } op_t;

    // Deepest pipeline the block is meant to be built with.
    localparam int MAX_STAGES = 4;

    // Width of one lane when the datapath is partitioned.
    function automatic int lane_width(input int width, input int parts);
        return width / parts;
    endfunction

endpackage

// File: rtl/addsub_mx_lane.sv
// One L-bit combinational add/sub lane. In full-width mode lanes are chained
// through chain_in/chain_out (a raw adder carry, i.e. inverted borrow when
// subtracting); saturation and averaging are applied only by the MSB lane.
module addsub_mx_lane
    import addsub_mx_pkg::*;
#(
    parameter int L = 8
) (
    input  logic [L-1:0] a,
    input  logic [L-1:0] b,
    input  logic         ci,
    input  op_t          op,
    input  logic         chain_in,
    input  logic         is_msb_lane,
    output logic [L-1:0] res,
    output logic         co,
    output logic         ovf,
    output logic         chain_out
);

    logic [L-1:0] bx_s;
    logic         cx_s;
    logic [L:0]   raw_s;
    logic [L:0]   r_s;
    logic         ext_a_s;
    logic         ext_b_s;
    logic [L-1:0] satv_s;

    // Lane arithmetic: subtraction is a + ~b + ~borrow, the extended top bit
    // of r is rebuilt from the operand extension bits and the adder carry.
    always_comb begin
        bx_s      = op.addsub ? ~b : b;
        cx_s      = op.split ? (ci ^ op.addsub) : chain_in;
        raw_s     = {1'b0, a} + {1'b0, bx_s} + {{L{1'b0}}, cx_s};
        chain_out = raw_s[L];
        ext_a_s   = op.tc & a[L-1];
        ext_b_s   = op.tc ? bx_s[L-1] : op.addsub;
        r_s       = {ext_a_s ^ ext_b_s ^ raw_s[L], raw_s[L-1:0]};
        co        = raw_s[L] ^ op.addsub;
        if (op.tc) begin
            ovf = r_s[L] ^ r_s[L-1];
        end else begin
            ovf = co;
        end
        if (!op.tc) begin
            satv_s = op.addsub ? {L{1'b0}} : {L{1'b1}};
        end else if (r_s[L]) begin
            satv_s = {1'b1, {(L-1){1'b0}}};
        end else begin
            satv_s = {1'b0, {(L-1){1'b1}}};
        end
        if (!is_msb_lane) begin
            res = r_s[L-1:0];
        end else if (op.avg) begin
            res = r_s[L:1];
        end else if (op.sat && ovf) begin
            res = satv_s;
        end else begin
            res = r_s[L-1:0];
        end
    end

endmodule

// File: rtl/addsub_mx_pipe.sv
// Pipelined partitionable adder/subtractor with a valid/ready stream on each
// side. Arithmetic is resolved before the first register; the remaining
// stages only retime payload and valid. The whole pipe stalls as one.
module addsub_mx_pipe
    import addsub_mx_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int PARTS  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [PARTS-1:0] ci,
    input  logic             addsub,
    input  logic             tc,
    input  logic             sat,
    input  logic             avg,
    input  logic             split,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic [PARTS-1:0] co,
    output logic [PARTS-1:0] ovf
);

    localparam int L = lane_width(WIDTH, PARTS);

    op_t              op_s;
    logic [WIDTH-1:0] lane_res_s;
    logic [PARTS-1:0] lane_co_s;
    logic [PARTS-1:0] lane_ovf_s;
    logic [PARTS-1:0] lane_chain_s;
    logic [PARTS-1:0] chain_in_s;
    logic [WIDTH-1:0] res_s;
    logic [PARTS-1:0] co_s;
    logic [PARTS-1:0] ovf_s;
    logic             fill_s;
    logic             sat_act_s;
    logic             top_r0_s;
    logic             advance_s;

    logic [WIDTH-1:0] sum_pipe_r [STAGES];
    logic [PARTS-1:0] co_pipe_r  [STAGES];
    logic [PARTS-1:0] ovf_pipe_r [STAGES];
    logic [STAGES-1:0] valid_pipe_r;

    // Bundle the per-beat controls for the lanes.
    always_comb begin
        op_s.addsub = addsub;
        op_s.tc     = tc;
        op_s.sat    = sat;
        op_s.avg    = avg;
        op_s.split  = split;
    end

    for (genvar k = 0; k < PARTS; k++) begin : g_lane
        localparam logic IS_TOP = (k == PARTS - 1);
        if (k == 0) begin : g_first
            assign chain_in_s[k] = ci[0] ^ addsub;
        end else begin : g_rest
            assign chain_in_s[k] = lane_chain_s[k-1];
        end
        addsub_mx_lane #(.L(L)) u_lane (
            .a           (a[k*L +: L]),
            .b           (b[k*L +: L]),
            .ci          (ci[k]),
            .op          (op_s),
            .chain_in    (chain_in_s[k]),
            .is_msb_lane (split | IS_TOP),
            .res         (lane_res_s[k*L +: L]),
            .co          (lane_co_s[k]),
            .ovf         (lane_ovf_s[k]),
            .chain_out   (lane_chain_s[k])
        );
    end

    // Full-width fixup of the lower lanes: shift in for averaging, flood with
    // the saturation fill (taken from the MSB lane's saturated value).
    always_comb begin
        res_s     = lane_res_s;
        co_s      = lane_co_s;
        ovf_s     = lane_ovf_s;
        fill_s    = lane_res_s[WIDTH-1] ^ tc;
        sat_act_s = sat & ~avg & lane_ovf_s[PARTS-1];
        top_r0_s  = a[WIDTH-L] ^ b[WIDTH-L] ^ addsub ^ chain_in_s[PARTS-1];
        if (!split) begin
            for (int i = 0; i < WIDTH - L; i++) begin
                if (avg) begin
                    if (i == WIDTH - L - 1) begin
                        res_s[i] = top_r0_s;
                    end else begin
                        res_s[i] = lane_res_s[i+1];
                    end
                end else if (sat_act_s) begin
                    res_s[i] = fill_s;
                end else begin
                    res_s[i] = lane_res_s[i];
                end
            end
            co_s             = {PARTS{1'b0}};
            ovf_s            = {PARTS{1'b0}};
            co_s[PARTS-1]    = lane_chain_s[PARTS-1] ^ addsub;
            ovf_s[PARTS-1]   = lane_ovf_s[PARTS-1];
        end else begin
            co_s  = lane_co_s;
            ovf_s = lane_ovf_s;
        end
    end

    // The pipe moves only when the output register is free or being drained.
    assign advance_s = ~(out_valid & ~out_ready);
    assign in_ready  = advance_s;

    // Payload/valid pipeline; bubbles travel like beats so none collapse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_pipe_r <= {STAGES{1'b0}};
            for (int s = 0; s < STAGES; s++) begin
                sum_pipe_r[s] <= {WIDTH{1'b0}};
                co_pipe_r[s]  <= {PARTS{1'b0}};
                ovf_pipe_r[s] <= {PARTS{1'b0}};
            end
        end else if (advance_s) begin
            valid_pipe_r[0] <= in_valid;
            sum_pipe_r[0]   <= res_s;
            co_pipe_r[0]    <= co_s;
            ovf_pipe_r[0]   <= ovf_s;
            for (int s = 1; s < STAGES; s++) begin
                valid_pipe_r[s] <= valid_pipe_r[s-1];
                sum_pipe_r[s]   <= sum_pipe_r[s-1];
                co_pipe_r[s]    <= co_pipe_r[s-1];
                ovf_pipe_r[s]   <= ovf_pipe_r[s-1];
            end
        end
    end

    assign out_valid = valid_pipe_r[STAGES-1];
    assign sum       = sum_pipe_r[STAGES-1];
    assign co        = co_pipe_r[STAGES-1];
    assign ovf       = ovf_pipe_r[STAGES-1];

endmodule

// File: tb/tb_addsub_mx_pipe.sv
// Scoreboard bench for addsub_mx_pipe (WIDTH=32, PARTS=4, STAGES=2).
module tb_addsub_mx_pipe;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ci;
        logic        addsub;
        logic        tc;
        logic        sat;
        logic        avg;
        logic        split;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        logic [3:0]  co;
        logic [3:0]  ovf;
        bit          lat_chk;
        int          acc_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ci;
    logic        addsub;
    logic        tc;
    logic        sat;
    logic        avg;
    logic        split;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic [3:0]  co;
    logic [3:0]  ovf;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t q[$];
    bit   front_seen = 1'b0;

    addsub_mx_pipe #(.WIDTH(32), .PARTS(4), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .addsub(addsub), .tc(tc), .sat(sat),
        .avg(avg), .split(split), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .co(co), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Free-running cycle count used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] va, input logic [31:0] vb, input logic [3:0] vci,
                                input logic vas, input logic vtc, input logic vsat,
                                input logic vavg, input logic vsplit);
        vec_t v;
        v.a = va; v.b = vb; v.ci = vci; v.addsub = vas; v.tc = vtc;
        v.sat = vsat; v.avg = vavg; v.split = vsplit;
        return v;
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] s, input logic [3:0] c, input logic [3:0] o, input bit lc);
        exp_t e;
        e.sum = s; e.co = c; e.ovf = o; e.lat_chk = lc; e.acc_cyc = 0;
        return e;
    endfunction

    // Reference model: exact integer arithmetic on each lane.
    function automatic exp_t model(input vec_t v);
        exp_t   e;
        int     lw, np, idx;
        longint mask, ua, ub, sa, sb, c, rv, rm, res;
        logic   cob, rl, rl1, ov;
        e.sum = 32'h0; e.co = 4'h0; e.ovf = 4'h0; e.lat_chk = 1'b0; e.acc_cyc = 0;
        lw = v.split ? 8 : 32;
        np = v.split ? 4 : 1;
        mask = (longint'(1) << lw) - 1;
        for (int k = 0; k < np; k++) begin
            ua = (longint'(v.a) >> (k*lw)) & mask;
            ub = (longint'(v.b) >> (k*lw)) & mask;
            sa = (v.tc && ua[lw-1]) ? ua - (longint'(1) << lw) : ua;
            sb = (v.tc && ub[lw-1]) ? ub - (longint'(1) << lw) : ub;
            c  = longint'(v.ci[k]);
            rv = v.addsub ? sa - sb - c : sa + sb + c;
            rm = rv & ((longint'(1) << (lw+1)) - 1);
            cob = v.addsub ? (ua < ub + c) : ((((ua + ub + c) >> lw) & 1) == 1);
            rl  = rm[lw];
            rl1 = rm[lw-1];
            ov  = v.tc ? (rl ^ rl1) : cob;
            if (v.avg)          res = (rm >> 1) & mask;
            else if (v.sat && ov) begin
                if (!v.tc)      res = v.addsub ? 0 : mask;
                else if (rl)    res = longint'(1) << (lw-1);
                else            res = (longint'(1) << (lw-1)) - 1;
            end else            res = rm & mask;
            e.sum = e.sum | 32'(res << (k*lw));
            idx = v.split ? k : 3;
            e.co[idx]  = cob;
            e.ovf[idx] = ov;
        end
        return e;
    endfunction

    task automatic send_beat(input vec_t v, input exp_t e);
        int n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; a = v.a; b = v.b; ci = v.ci; addsub = v.addsub;
        tc = v.tc; sat = v.sat; avg = v.avg; split = v.split;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout actual=in_ready_low required=accept");
        end else begin
            e.acc_cyc = cyc;
            q.push_back(e);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d pending required=0", q.size());
            q.delete();
        end
    endtask

    // Monitor: handshake rule, stall stability, and scoreboard compare.
    initial begin : monitor
        exp_t        e;
        bit          prev_stall = 1'b0;
        logic [31:0] prev_sum;
        logic [3:0]  prev_co, prev_ovf;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                front_seen = 1'b0;
            end else begin
                chk("in_ready_rule", {31'h0, in_ready}, {31'h0, ~(out_valid & ~out_ready)});
                if (prev_stall) begin
                    chk("stall_sum", sum, prev_sum);
                    chk("stall_co", {28'h0, co}, {28'h0, prev_co});
                    chk("stall_ovf", {28'h0, ovf}, {28'h0, prev_ovf});
                end
                if (out_valid) begin
                    if (q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_output actual=%h required=none", sum);
                    end else begin
                        e = q[0];
                        if (e.lat_chk && !front_seen)
                            chk("latency", 32'(cyc - e.acc_cyc), 32'd2);
                        front_seen = 1'b1;
                        if (out_ready) begin
                            chk("sum", sum, e.sum);
                            chk("co", {28'h0, co}, {28'h0, e.co});
                            chk("ovf", {28'h0, ovf}, {28'h0, e.ovf});
                            void'(q.pop_front());
                            front_seen = 1'b0;
                        end
                    end
                end
                prev_stall = out_valid & ~out_ready;
                prev_sum = sum; prev_co = co; prev_ovf = ovf;
            end
        end
    end

    vec_t mix[8];

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = 32'h0; b = 32'h0; ci = 4'h0; addsub = 1'b0; tc = 1'b0;
        sat = 1'b0; avg = 1'b0; split = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset_sum", sum, 32'h0);
        chk("reset_co_ovf", {24'h0, co, ovf}, 32'h0);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", {31'h0, in_ready}, 32'h1);

        // Lane add with saturation, plus signed sat/avg and full-width sub.
        send_beat(mk(32'hFF107F01, 32'h02F00101, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1),
                  mk_exp(32'hFFFF8002, 4'b1100, 4'b1100, 1'b1));
        send_beat(mk(32'h7F807F80, 32'h01FF01FF, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1),
                  mk_exp(32'h7F807F80, 4'b0101, 4'b1111, 1'b0));
        send_beat(mk(32'h7F807F80, 32'h01FF01FF, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1),
                  mk_exp(32'h40BF40BF, 4'b0101, 4'b1111, 1'b0));
        send_beat(mk(32'h00000000, 32'h00000001, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0),
                  mk_exp(32'hFFFFFFFF, 4'b1000, 4'b1000, 1'b0));
        send_beat(mk(32'h00000000, 32'h00000001, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0),
                  mk_exp(32'h00000000, 4'b1000, 4'b1000, 1'b0));
        idle();
        drain();

        // Backpressure: six streamed beats while the sink stalls for three cycles.
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    vec_t v;
                    v = mk(32'h01010101 * i + 32'hF0E0D0C0, 32'h10203040, 4'(i),
                           1'(i % 3 == 1), 1'(i % 2), 1'b0, 1'b0, 1'(i % 2 == 0));
                    send_beat(v, model(v));
                end
                idle();
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight, then a clean beat afterwards.
        send_beat(mk(32'h11111111, 32'h22222222, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1),
                  mk_exp(32'h33333333, 4'h0, 4'h0, 1'b0));
        send_beat(mk(32'h44444444, 32'h11111111, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
                  mk_exp(32'h55555555, 4'h0, 4'h0, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("midrst_sum", sum, 32'h0);
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("postrst_in_ready", {31'h0, in_ready}, 32'h1);
        send_beat(mk(32'h000000FF, 32'h00000001, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
                  mk_exp(32'h00000100, 4'h0, 4'h0, 1'b1));
        idle();
        drain();

        // Mixed modes back to back: carries must not leak between beats.
        mix[0] = mk(32'hFFFFFFFF, 32'h00000001, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        mix[1] = mk(32'h00000000, 32'h00000000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        mix[2] = mk(32'h80007F05, 32'h0101FF06, 4'h1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        mix[3] = mk(32'h7FFFFFFF, 32'h00000001, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        mix[4] = mk(32'hFF018003, 32'hFF018001, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        mix[5] = mk(32'h80000000, 32'h00000001, 4'h1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        mix[6] = mk(32'h12345678, 32'h11223344, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        mix[7] = mk(32'hFFFFFFF0, 32'h00000010, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_beat(mix[i], model(mix[i]));
        idle();
        drain();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
